alu_seq_ctrl: RTL and testbench

- Multi-cycle sequencer that owns one 4-bit `alu` instance and a 4-entry operand register file.
- Accepts 16-bit commands over a valid/ready handshake, drives the ALU operand/opcode inputs from registers, and writes the result back to a destination register.
- A command can repeat the same op up to 16 times, accumulating into the destination (e.g. multiply by repeated add).
- Sits between a host/test controller and the `alu` datapath.

---
 rtl/alu_seq_ctrl.sv | 105 ++++++++++
 tb/tb_alu_seq_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer driving a 4-bit ALU from a 4-entry register file, with repeat-accumulate.
// done fires rpt+1 cycles after the accept edge; cmd_ready is low from accept until back in IDLE.
module alu_seq_ctrl #(
  parameter int DATA_W = 4,
  parameter int RPT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [15:0]       cmd,
  input  logic              wr_en,
  input  logic [1:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [1:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_f,
  input  logic              alu_carry,
  input  logic              alu_zero,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] res_data,
  output logic              res_carry,
  output logic              res_zero
);

  typedef struct packed {
    logic [2:0]       op;
    logic [1:0]       rd;
    logic [1:0]       rs1;
    logic [1:0]       rs2;
    logic [RPT_W-1:0] rpt;
    logic [6-RPT_W:0] rsvd;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, EXEC, DONE_S} state_t;

  state_t            state;
  cmd_t              c;
  logic [DATA_W-1:0] regs [4];
  logic [RPT_W-1:0]  cnt;
  logic [1:0]        rd_q;
  logic              carry_acc;
  logic              unused_rsvd;

  assign c           = cmd;
  assign unused_rsvd = ^c.rsvd;
  assign cmd_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign rd_data     = regs[rd_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      cnt        <= '0;
      rd_q       <= '0;
      carry_acc  <= 1'b0;
      done       <= 1'b0;
      res_data   <= '0;
      res_carry  <= 1'b0;
      res_zero   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // Operands read here see the pre-write value when wr_en coincides with accept.
          if (wr_en) regs[wr_addr] <= wr_data;
          if (cmd_valid) begin
            alu_a      <= regs[c.rs1];
            alu_b      <= regs[c.rs2];
            alu_opcode <= c.op;
            cnt        <= c.rpt;
            rd_q       <= c.rd;
            carry_acc  <= 1'b0;
            state      <= EXEC;
          end
        end
        EXEC: begin
          regs[rd_q] <= alu_f;
          carry_acc  <= carry_acc | alu_carry;
          if (cnt != '0) begin
            cnt   <= cnt - RPT_W'(1);
            alu_a <= alu_f;
          end else begin
            res_data  <= alu_f;
            res_carry <= carry_acc | alu_carry;
            res_zero  <= alu_zero;
            done      <= 1'b1;
            state     <= DONE_S;
          end
        end
        DONE_S: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural 4-bit ALU closing the loop.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [3:0]  wr_data;
  logic [1:0]  rd_addr;
  logic [3:0]  rd_data;
  logic [3:0]  alu_a, alu_b;
  logic [2:0]  alu_opcode;
  logic [3:0]  alu_f;
  logic        alu_carry, alu_zero;
  logic        busy, done;
  logic [3:0]  res_data;
  logic        res_carry, res_zero;
  logic [4:0]  alu_t;

  int checks   = 0;
  int failures = 0;

  alu_seq_ctrl #(.DATA_W(4), .RPT_W(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_f(alu_f),
    .alu_carry(alu_carry), .alu_zero(alu_zero), .busy(busy), .done(done),
    .res_data(res_data), .res_carry(res_carry), .res_zero(res_zero)
  );

  always #5 clk = ~clk;

  // Reference ALU: carry is carry-out for add/inc, borrow for sub/dec.
  always_comb begin
    alu_t = '0;
    case (alu_opcode)
      3'd0: alu_t = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1: alu_t = {1'b0, alu_a} - {1'b0, alu_b};
      3'd2: alu_t = {1'b0, alu_a & alu_b};
      3'd3: alu_t = {1'b0, alu_a | alu_b};
      3'd4: alu_t = {1'b0, alu_a ^ alu_b};
      3'd5: alu_t = {1'b0, ~alu_a};
      3'd6: alu_t = {1'b0, alu_a} + 5'd1;
      default: alu_t = {1'b0, alu_a} - 5'd1;
    endcase
  end
  assign alu_f     = alu_t[3:0];
  assign alu_carry = alu_t[4];
  assign alu_zero  = (alu_t[3:0] == 4'd0);

  typedef struct {
    logic [2:0] op;
    logic [1:0] rd, rs1, rs2;
    logic [3:0] rpt;
    logic [3:0] r0, r1, r2, r3;
    logic [3:0] e_res;
    logic       e_c, e_z;
    int         e_lat;
  } vec_t;

  vec_t vt [7];
  int   seqa [4];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [1:0] rd,
                                     input logic [1:0] rs1, input logic [1:0] rs2,
                                     input logic [3:0] rpt);
    return {op, rd, rs1, rs2, rpt, 3'b111};
  endfunction

  task automatic wr(input logic [1:0] a, input logic [3:0] d);
    @(negedge clk); wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk); wr_en = 1'b0;
  endtask

  task automatic issue(input logic [15:0] c, input logic w, input logic [1:0] wa, input logic [3:0] wd);
    @(negedge clk); cmd_valid = 1'b1; cmd = c; wr_en = w; wr_addr = wa; wr_data = wd;
    @(negedge clk); cmd_valid = 1'b0; wr_en = 1'b0;
  endtask

  // Counts edges from the accept edge (inclusive) until done is seen.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("done_seen", int'(done), 1);
  endtask

  task automatic chk_reg(input string name, input logic [1:0] a, input int exp);
    rd_addr = a;
    #1;
    check(name, int'(rd_data), exp);
  endtask

  initial begin
    int lat;
    int acc1, acc2, dones, seen_done;

    //        op    rd rs1 rs2 rpt   r0 r1 r2 r3  res c z lat
    vt[0] = '{3'd0, 2, 0, 1, 4'd0,  5, 3, 0, 0,  8, 0, 0, 2};
    vt[1] = '{3'd1, 3, 1, 0, 4'd0,  5, 3, 0, 0, 14, 1, 0, 2};
    vt[2] = '{3'd0, 0, 0, 1, 4'd3,  5, 3, 0, 0,  1, 1, 0, 5};
    vt[3] = '{3'd6, 1, 1, 0, 4'd0,  0,15, 0, 0,  0, 1, 1, 2};
    vt[4] = '{3'd7, 1, 1, 0, 4'd0,  0, 0, 0, 0, 15, 1, 0, 2};
    vt[5] = '{3'd0, 2, 0, 1, 4'd15, 1, 1, 0, 0,  1, 1, 0, 17};
    vt[6] = '{3'd1, 0, 2, 2, 4'd0,  9, 9, 6, 0,  0, 0, 1, 2};
    seqa  = '{8, 11, 14, 1};

    rst = 1'b1; cmd_valid = 1'b0; cmd = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_alu_a", int'(alu_a), 0);
    check("rst_res", int'(res_data), 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", int'(cmd_ready), 1);
    chk_reg("rst_r0", 2'd0, 0);

    for (int i = 0; i < 7; i++) begin
      wr(2'd0, vt[i].r0); wr(2'd1, vt[i].r1); wr(2'd2, vt[i].r2); wr(2'd3, vt[i].r3);
      issue(mk(vt[i].op, vt[i].rd, vt[i].rs1, vt[i].rs2, vt[i].rpt), 1'b0, 2'd0, 4'd0);
      wait_done(lat);
      check($sformatf("v%0d_lat", i), lat, vt[i].e_lat);
      check($sformatf("v%0d_res", i), int'(res_data), int'(vt[i].e_res));
      check($sformatf("v%0d_carry", i), int'(res_carry), int'(vt[i].e_c));
      check($sformatf("v%0d_zero", i), int'(res_zero), int'(vt[i].e_z));
      chk_reg($sformatf("v%0d_rd", i), vt[i].rd, int'(vt[i].e_res));
    end

    // Intermediate writebacks visible on rd_data while accumulating.
    wr(2'd0, 4'd5); wr(2'd1, 4'd3);
    rd_addr = 2'd0;
    issue(mk(3'd0, 2'd0, 2'd0, 2'd1, 4'd3), 1'b0, 2'd0, 4'd0);
    check("seqa_busy", int'(busy), 1);
    check("seqa_ready", int'(cmd_ready), 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      check($sformatf("seqa_r0_%0d", k), int'(rd_data), seqa[k]);
    end
    check("seqa_done", int'(done), 1);

    // Host write on the accept edge: commits, but the command sees the old value.
    wr(2'd0, 4'd2);
    issue(mk(3'd0, 2'd2, 2'd0, 2'd0, 4'd0), 1'b1, 2'd0, 4'd9);
    wait_done(lat);
    check("hazA_res", int'(res_data), 4);
    chk_reg("hazA_r0", 2'd0, 9);

    // Host write during EXEC is dropped.
    wr(2'd3, 4'd1);
    issue(mk(3'd0, 2'd2, 2'd0, 2'd1, 4'd3), 1'b0, 2'd0, 4'd0);
    @(negedge clk); wr_en = 1'b1; wr_addr = 2'd3; wr_data = 4'd7;
    @(negedge clk); wr_en = 1'b0;
    wait_done(lat);
    chk_reg("hazB_r3", 2'd3, 1);

    // cmd_valid held high: second accept waits until after done.
    wr(2'd0, 4'd1); wr(2'd1, 4'd2);
    acc1 = -1; acc2 = -1; dones = 0;
    @(negedge clk); cmd_valid = 1'b1; cmd = mk(3'd0, 2'd0, 2'd0, 2'd1, 4'd0);
    for (int cyc = 0; cyc < 20 && dones < 2; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (done) dones++;
      if (dones >= 2) cmd_valid = 1'b0;
      else if (cmd_ready) begin
        if (acc1 < 0) acc1 = cyc;
        else if (acc2 < 0) acc2 = cyc;
      end
    end
    cmd_valid = 1'b0;
    check("hold_dones", dones, 2);
    check("hold_gap", acc2 - acc1, 3);
    check("hold_res", int'(res_data), 5);
    chk_reg("hold_r0", 2'd0, 5);

    // Reset in the middle of a long command.
    wr(2'd0, 4'd1); wr(2'd1, 4'd1);
    issue(mk(3'd0, 2'd2, 2'd0, 2'd1, 4'd5), 1'b0, 2'd0, 4'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_alu_a", int'(alu_a), 0);
    check("abort_alu_b", int'(alu_b), 0);
    check("abort_alu_op", int'(alu_opcode), 0);
    check("abort_res", int'(res_data), 0);
    check("abort_carry", int'(res_carry), 0);
    for (int r = 0; r < 4; r++) chk_reg($sformatf("abort_r%0d", r), 2'(r), 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("abort_ready", int'(cmd_ready), 1);
    seen_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    check("abort_no_done", seen_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
